// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall encodings,
// FSM states and the timeout-counter width helper.
package pipe_ctrl_pkg;

    localparam int STALL_WIDTH = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [STALL_WIDTH-1:0] STALL_NONE     = 6'b000000;
    localparam logic [STALL_WIDTH-1:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [STALL_WIDTH-1:0] STALL_MEM      = 6'b011111;

    typedef enum logic {
        PCTRL_RUN      = 1'b0,
        PCTRL_MEM_WAIT = 1'b1
    } pctrl_state_e;

    // A zero timeout still needs a 1-bit counter so the register is never empty.
    function automatic int tmo_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/jump/bus handshake between the pipeline datapath (master) and the
// pipeline controller (slave).
interface pipe_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
);
    logic [RADDR_WIDTH-1:0] id_rs1_i;
    logic                   id_rs1_re_i;
    logic [RADDR_WIDTH-1:0] id_rs2_i;
    logic                   id_rs2_re_i;
    logic                   ex_inst_is_load_i;
    logic [RADDR_WIDTH-1:0] ex_rd_i;
    logic                   jump_req_i;
    logic [ADDR_WIDTH-1:0]  jump_addr_i;
    logic                   mem_req_i;
    logic                   mem_ack_i;
    logic [STALL_WIDTH-1:0] stall_o;
    logic                   flush_jump_o;
    logic [ADDR_WIDTH-1:0]  jump_addr_o;
    logic                   bus_err_o;

    modport master (
        output id_rs1_i, id_rs1_re_i, id_rs2_i, id_rs2_re_i,
               ex_inst_is_load_i, ex_rd_i, jump_req_i, jump_addr_i,
               mem_req_i, mem_ack_i,
        input  stall_o, flush_jump_o, jump_addr_o, bus_err_o
    );

    modport slave (
        input  id_rs1_i, id_rs1_re_i, id_rs2_i, id_rs2_re_i,
               ex_inst_is_load_i, ex_rd_i, jump_req_i, jump_addr_i,
               mem_req_i, mem_ack_i,
        output stall_o, flush_jump_o, jump_addr_o, bus_err_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use detector: the ID instruction needs a register that
// the load currently in EXE has not produced yet.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
#(
    parameter int RADDR_WIDTH = 5
) (
    input  logic [RADDR_WIDTH-1:0] id_rs1,
    input  logic                   id_rs1_re,
    input  logic [RADDR_WIDTH-1:0] id_rs2,
    input  logic                   id_rs2_re,
    input  logic                   ex_inst_is_load,
    input  logic [RADDR_WIDTH-1:0] ex_rd,
    output logic                   load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_re && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_re && (id_rs2 == ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_inst_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall/flush generation with a bus-wait FSM.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o,
`endif
    pipe_ctrl_if.slave  ctrl
);

    localparam int TMO_W = tmo_width(MEM_TIMEOUT);

    pctrl_state_e           state_q, state_d;
    logic                   pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;

    logic                   load_use;
    logic                   timeout;
    logic [STALL_WIDTH-1:0] stall_c;
    logic                   flush_c;
    logic [ADDR_WIDTH-1:0]  addr_c;
    logic                   err_c;

    pipe_hazard_det #(
        .RADDR_WIDTH (RADDR_WIDTH)
    ) u_hazard (
        .id_rs1          (ctrl.id_rs1_i),
        .id_rs1_re       (ctrl.id_rs1_re_i),
        .id_rs2          (ctrl.id_rs2_i),
        .id_rs2_re       (ctrl.id_rs2_re_i),
        .ex_inst_is_load (ctrl.ex_inst_is_load_i),
        .ex_rd           (ctrl.ex_rd_i),
        .load_use        (load_use)
    );

    assign timeout = (MEM_TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(MEM_TIMEOUT)) && !ctrl.mem_ack_i;

    // Priority: bus wait, then EXE jump, then load-use.
    always_comb begin
        stall_c     = STALL_NONE;
        flush_c     = 1'b0;
        addr_c      = '0;
        err_c       = 1'b0;
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            PCTRL_RUN: begin
                if (ctrl.mem_req_i && !ctrl.mem_ack_i) begin
                    stall_c   = STALL_MEM;
                    state_d   = PCTRL_MEM_WAIT;
                    tmo_cnt_d = TMO_W'(1);
                    if (ctrl.jump_req_i) begin
                        pend_d      = 1'b1;
                        pend_addr_d = ctrl.jump_addr_i;
                    end
                end else if (ctrl.jump_req_i) begin
                    flush_c = 1'b1;
                    addr_c  = ctrl.jump_addr_i;
                end else if (load_use) begin
                    stall_c = STALL_LOAD_USE;
                end
            end
            PCTRL_MEM_WAIT: begin
                if (ctrl.mem_ack_i || timeout) begin
                    state_d   = PCTRL_RUN;
                    tmo_cnt_d = '0;
                    err_c     = timeout;
                    pend_d    = 1'b0;
                    if (pend_q || ctrl.jump_req_i) begin
                        flush_c = 1'b1;
                        addr_c  = pend_q ? pend_addr_q : ctrl.jump_addr_i;
                    end
                end else begin
                    stall_c = STALL_MEM;
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                    // The first jump seen during the wait is the one that gets issued.
                    if (ctrl.jump_req_i && !pend_q) begin
                        pend_d      = 1'b1;
                        pend_addr_d = ctrl.jump_addr_i;
                    end
                end
            end
            default: begin
                state_d = PCTRL_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= PCTRL_RUN;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign ctrl.stall_o      = rst_i ? STALL_NONE : stall_c;
    assign ctrl.flush_jump_o = rst_i ? 1'b0 : flush_c;
    assign ctrl.jump_addr_o  = rst_i ? '0 : addr_c;
    assign ctrl.bus_err_o    = rst_i ? 1'b0 : err_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (ctrl.stall_o != STALL_NONE) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (ctrl.flush_jump_o) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed cycle table for the corner cases, then random
// traffic against a queue-based behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TB_TMO = 4;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1;
        logic        rs1Re;
        logic [4:0]  rs2;
        logic        rs2Re;
        logic        isLoad;
        logic [4:0]  exRd;
        logic        jReq;
        logic [31:0] jAddr;
        logic        mReq;
        logic        mAck;
        logic [5:0]  expStall;
        logic        expFlush;
        logic [31:0] expAddr;
        logic        expErr;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bit   mWaiting;
    int   mWaitLen;
    logic [31:0] mPend[$];

    pipe_ctrl_if #(.ADDR_WIDTH(32), .RADDR_WIDTH(5)) bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perfStall;
    logic [31:0] perfFlush;
`endif

    pipe_ctrl #(
        .ADDR_WIDTH  (32),
        .RADDR_WIDTH (5),
        .MEM_TIMEOUT (TB_TMO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt_o (perfStall),
        .perf_flush_cnt_o (perfFlush),
`endif
        .ctrl             (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input logic rs, input logic [4:0] r1, input logic r1e, input logic [4:0] r2, input logic r2e,
        input logic ld, input logic [4:0] rd, input logic jr, input logic [31:0] ja,
        input logic mr, input logic ma, input logic [5:0] es, input logic ef,
        input logic [31:0] ea, input logic ee);
        vec_t v;
        v.rst = rs; v.rs1 = r1; v.rs1Re = r1e; v.rs2 = r2; v.rs2Re = r2e;
        v.isLoad = ld; v.exRd = rd; v.jReq = jr; v.jAddr = ja;
        v.mReq = mr; v.mAck = ma; v.expStall = es; v.expFlush = ef;
        v.expAddr = ea; v.expErr = ee;
        return v;
    endfunction

    // Reference: outputs and next state derived directly from the controller's rules.
    task automatic modelStep(inout vec_t v);
        bit lu;
        bit tmo;
        lu = v.isLoad && (v.exRd != 0) &&
             ((v.rs1Re && v.rs1 == v.exRd) || (v.rs2Re && v.rs2 == v.exRd));
        v.expStall = 6'd0; v.expFlush = 1'b0; v.expAddr = 32'd0; v.expErr = 1'b0;
        if (v.rst) begin
            mWaiting = 0; mWaitLen = 0; mPend.delete();
        end else if (!mWaiting) begin
            if (v.mReq && !v.mAck) begin
                v.expStall = 6'd31;
                if (v.jReq) mPend.push_back(v.jAddr);
                mWaiting = 1; mWaitLen = 1;
            end else if (v.jReq) begin
                v.expFlush = 1'b1; v.expAddr = v.jAddr;
            end else if (lu) begin
                v.expStall = 6'd7;
            end
        end else begin
            tmo = (TB_TMO != 0) && (mWaitLen == TB_TMO) && !v.mAck;
            if (v.mAck || tmo) begin
                v.expErr = tmo;
                if (mPend.size() > 0 || v.jReq) begin
                    v.expFlush = 1'b1;
                    v.expAddr  = (mPend.size() > 0) ? mPend[0] : v.jAddr;
                end
                mPend.delete(); mWaiting = 0; mWaitLen = 0;
            end else begin
                v.expStall = 6'd31;
                mWaitLen = mWaitLen + 1;
                if (v.jReq && mPend.size() == 0) mPend.push_back(v.jAddr);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst                   = v.rst;
        bus.id_rs1_i          = v.rs1;
        bus.id_rs1_re_i       = v.rs1Re;
        bus.id_rs2_i          = v.rs2;
        bus.id_rs2_re_i       = v.rs2Re;
        bus.ex_inst_is_load_i = v.isLoad;
        bus.ex_rd_i           = v.exRd;
        bus.jump_req_i        = v.jReq;
        bus.jump_addr_i       = v.jAddr;
        bus.mem_req_i         = v.mReq;
        bus.mem_ack_i         = v.mAck;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v);
        #3;
        checkOutput("stall", idx, {26'd0, bus.stall_o}, {26'd0, v.expStall});
        checkOutput("flush", idx, {31'd0, bus.flush_jump_o}, {31'd0, v.expFlush});
        checkOutput("bus_err", idx, {31'd0, bus.bus_err_o}, {31'd0, v.expErr});
        if (v.expFlush) checkOutput("jump_addr", idx, bus.jump_addr_o, v.expAddr);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.id_rs1_i = '0; bus.id_rs1_re_i = 1'b0; bus.id_rs2_i = '0; bus.id_rs2_re_i = 1'b0;
        bus.ex_inst_is_load_i = 1'b0; bus.ex_rd_i = '0; bus.jump_req_i = 1'b0;
        bus.jump_addr_i = '0; bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;

        //                rst rs1 re rs2 re ld rd jr addr          mr ma  stall  fl addr          err
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 1, 5, 0, 32'h0,   0, 0, 6'h07, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 32'h0,   0, 0, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,   0, 0, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 7, 1, 0, 0, 1, 7, 0, 32'h0,   0, 0, 6'h07, 0, 32'h0,   0));
        tbl.push_back(mk(0, 7, 0, 0, 0, 1, 7, 0, 32'h0,   0, 0, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 1, 5, 1, 32'h100, 0, 0, 6'h00, 1, 32'h100, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 1, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h44,  1, 1, 6'h00, 1, 32'h44,  0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 1, 6'h00, 1, 32'h200, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 6'h1F, 0, 32'h0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 6'h00, 0, 32'h0,   1));
        tbl.push_back(mk(0, 0, 0, 5, 1, 1, 5, 0, 32'h0,   0, 0, 6'h07, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h500, 1, 1, 6'h00, 1, 32'h400, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h600, 1, 0, 6'h1F, 0, 32'h0,   0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 32'h700, 1, 0, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 1, 6'h00, 0, 32'h0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 6'h00, 0, 32'h0,   0));

        $display("[TB] directed table: %0d cycles", tbl.size());
        foreach (tbl[i]) runVector(tbl[i], i);

        // Timeout that also releases a jump captured on entry to the wait.
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 6'h00, 0, 32'h0, 0);
        mWaiting = 0; mWaitLen = 0; mPend.delete();
        modelStep(v); runVector(v, 1000);
        v = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h800, 1, 0, 6'h00, 0, 32'h0, 0);
        modelStep(v); runVector(v, 1001);
        for (int i = 0; i < TB_TMO; i++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 6'h00, 0, 32'h0, 0);
            modelStep(v); runVector(v, 1002 + i);
        end

        $display("[TB] random phase");
        for (int n = 0; n < 3000; n++) begin
            v.rst    = (n == 0) || ($urandom_range(0, 99) < 2);
            v.rs1    = 5'($urandom_range(0, 3));
            v.rs1Re  = 1'($urandom_range(0, 1));
            v.rs2    = 5'($urandom_range(0, 3));
            v.rs2Re  = 1'($urandom_range(0, 1));
            v.isLoad = 1'($urandom_range(0, 1));
            v.exRd   = 5'($urandom_range(0, 3));
            v.jReq   = ($urandom_range(0, 99) < 25);
            v.jAddr  = $urandom;
            v.mReq   = ($urandom_range(0, 99) < 50);
            v.mAck   = ($urandom_range(0, 99) < 35);
            modelStep(v);
            runVector(v, 2000 + n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
